// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared definitions for the instruction-fetch prefetch front end.
//   NOP_INST          : bubble instruction presented when nothing is buffered
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_entry_t     : one buffered fetch, {pc4, inst}
//   word_align()      : clears the byte-offset bits of an address
package fetch_prefetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_stage_fifo.sv
// prefetch_fifo: synchronous DEPTH-entry FIFO of {pc4, inst} records.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/push_data : write one entry at the tail
//   pop            : drop the head entry (caller guarantees non-empty)
//   clear          : empty the FIFO; takes priority over push and pop
//   head_data      : current head entry (meaningless while empty)
//   count/full/empty : occupancy status
module prefetch_fifo
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head_data,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: instruction-fetch front end ahead of IF/ID.
// Issues sequential word fetches (one outstanding at most), buffers the
// returned words tagged with PC+4, and presents the head to IF/ID.
//   clk, rst            : clock, asynchronous active-low reset
//   freeze              : hazard stall, head is held
//   br_taken/br_target  : flush and redirect fetch to br_target (word aligned)
//   imem_req/imem_addr  : fetch request and word address
//   imem_ack            : memory accepts the request this cycle
//   imem_rvalid/rdata   : read data return, later than the accepting cycle
//   PC/instruction      : head entry (PC+4 convention), zero when empty
//   inst_valid          : FIFO non-empty
module fetch_prefetch_stage
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        inst_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rec_pc4;
    logic          outstanding;
    logic          discard;

    logic          push;
    logic          pop;
    logic          completion;
    logic          outstanding_after;
    logic          accept;
    logic [CW:0]   occ_next;

    fetch_entry_t  push_data;
    fetch_entry_t  head_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    assign pop               = !empty && !freeze && !br_taken;
    assign completion        = outstanding && imem_rvalid;
    assign push              = completion && !discard && !br_taken;
    assign outstanding_after = outstanding && !imem_rvalid;

    // Slots committed after this cycle: entries left after the pop plus the
    // in-flight request. A returning word lands in the slot its request held,
    // so streaming at one word per cycle works with a single-cycle memory.
    assign occ_next = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(outstanding);

    // rst gating keeps the request low while the block is held in reset.
    assign imem_req  = rst && !br_taken && !outstanding_after
                       && (occ_next < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (br_taken) begin
            // Anything still in flight after a redirect is wrong-path.
            fetch_pc    <= word_align(br_target);
            outstanding <= outstanding_after || accept;
            discard     <= outstanding_after || accept;
        end else if (accept) begin
            fetch_pc    <= fetch_pc + 32'd4;
            outstanding <= 1'b1;
            discard     <= 1'b0;
        end else if (completion) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) rec_pc4 <= fetch_pc + 32'd4;
    end

    assign push_data = '{pc4: rec_pc4, inst: imem_rdata};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (br_taken),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign inst_valid  = !empty;
    assign PC          = empty ? 32'h0    : head_data.pc4;
    assign instruction = empty ? NOP_INST : head_data.inst;

    // The request/space accounting should make overflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                    !(push && full && !pop));

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
module tb_fetch_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        inst_valid;

    fetch_prefetch_stage #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .instruction (instruction),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        fz;
        logic        req;
        logic [31:0] addr;
        logic        vld;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    // Memory model: response arrives lat cycles after the accepting cycle.
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    bit          acc_prev = 1'b0;
    logic [31:0] addr_prev = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not seen within cycle budget", name);
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, before posedge.
    task automatic cyc(input logic fz, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        if (acc_prev) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = addr_prev;
        end
        imem_rvalid = pend && (cnt == 1);
        imem_rdata  = imem_rvalid ? (paddr | 32'hA000_0000) : 32'hDEAD_BEEF;
        if (pend) begin
            if (cnt == 1) pend = 1'b0;
            else cnt--;
        end
        freeze    = fz;
        br_taken  = br;
        br_target = tgt;
        #1;
        if (inst_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: valid head PC %h inst %h, none expected", PC, instruction);
            end else begin
                chk("sb_pc", PC, q[0].pc4);
                chk("sb_inst", instruction, q[0].inst);
                if (!fz && !br) void'(q.pop_front());
            end
        end else begin
            chk("bubble_pc", PC, 32'h0);
            chk("bubble_inst", instruction, 32'h0);
        end
        if (br) chk("br_req_low", {31'b0, imem_req}, 32'h0);
        acc_prev  = imem_req && imem_ack;
        addr_prev = imem_addr;
        if (br) q.delete();
        if (acc_prev && !br) q.push_back('{addr_prev + 32'd4, addr_prev | 32'hA000_0000});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        bit          found;
        bit          got_acc;
        logic [31:0] acc_a;
        int          last;
        int          ngap;

        // Startup at 1/cycle, then a 6-cycle freeze that fills the FIFO.
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'd8,  1'b1};
        tbl[3]  = '{1'b1, 1'b1, 32'd12, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 32'd16, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'd20, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'd20, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'd20, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'd20, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'd20, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'd24, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 32'd28, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'd32, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'd36, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst", instruction, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        lat = 1;
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].fz, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_vld", i), {31'b0, inst_valid}, {31'b0, tbl[i].vld});
        end

        // Slow memory: one entry every 4 cycles, bubbles in between.
        lat  = 4;
        last = -1;
        ngap = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (i >= 12 && inst_valid) begin
                if (last >= 0) begin
                    chk("lat_gap", 32'(i - last), 32'd4);
                    ngap++;
                end
                last = i;
            end
        end
        if (ngap == 0) fail_now("lat_gap_seen");

        // Redirect while a request is in flight.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (acc_prev || (pend && cnt >= 2)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("br_setup");
        cyc(1'b0, 1'b1, 32'h43);
        cyc(1'b0, 1'b0, 32'h0);
        chk("br_addr", imem_addr, 32'h40);
        got_acc = acc_prev;
        acc_a   = addr_prev;
        found   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (!got_acc && acc_prev) begin
                got_acc = 1'b1;
                acc_a   = addr_prev;
            end
            if (inst_valid) begin
                chk("br_first_pc", PC, 32'h44);
                chk("br_first_inst", instruction, 32'hA000_0040);
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("br_first_valid");
        chk("br_first_acc", acc_a, 32'h40);

        // br_taken, freeze and rvalid in the same cycle with a non-empty FIFO.
        lat = 1;
        repeat (6) cyc(1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (acc_prev && inst_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("tri_setup");
        cyc(1'b1, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, 32'h0);
        chk("tri_valid", {31'b0, inst_valid}, 32'h0);
        chk("tri_pc", PC, 32'h0);
        chk("tri_addr", imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (inst_valid) begin
                chk("tri_first_pc", PC, 32'h104);
                chk("tri_first_inst", instruction, 32'hA000_0100);
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("tri_first_valid");

        // Reset pulse mid-stream with a request outstanding.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (inst_valid && pend) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("rst_setup");
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, inst_valid}, 32'h0);
        chk("arst_pc", PC, 32'h0);
        chk("arst_inst", instruction, 32'h0);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        q.delete();
        acc_prev = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        // Stale response for the pre-reset request, one cycle after release.
        pend  = 1'b1;
        cnt   = 1;
        paddr = 32'h500;
        lat   = 1;
        cyc(1'b0, 1'b0, 32'h0);
        chk("rel_addr", imem_addr, 32'h0);
        chk("rel_valid", {31'b0, inst_valid}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (inst_valid) begin
                chk("rel_first_pc", PC, 32'h4);
                chk("rel_first_inst", instruction, 32'hA000_0000);
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_now("rel_first_valid");
        repeat (4) cyc(1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
